// File: rtl/mc_ctrl_pkg.sv
// Purpose : shared encodings for the miniRV multi-cycle control unit (states, classes, ALU ops, selects).
// Latency : n/a (types, constants and pure decode helpers only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_ERR = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_EXT  = 2'd3;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic ALUA_RD1 = 1'b0;
  localparam logic ALUA_PC  = 1'b1;
  localparam logic ALUB_RD2 = 1'b0;
  localparam logic ALUB_IMM = 1'b1;

  // alt selects SUB over ADD and SRA over SRL (instruction bit 30).
  function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Compare ops are chosen so that a flag of 1 always means "taken".
  function automatic logic [3:0] branch_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b001:  op = ALU_NE;
      3'b100:  op = ALU_SLT;
      3'b101:  op = ALU_GE;
      3'b110:  op = ALU_SLTU;
      3'b111:  op = ALU_GEU;
      default: op = ALU_EQ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Purpose : combinational instruction decode: opcode/funct3/funct7[5] -> class, alu_op, sext_op, wd_sel.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows inst.
// Ports: inst (instruction register) in; cls, alu_op, sext_op, wd_sel out.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output cls_e        cls,
  output logic [3:0]  alu_op,
  output logic [2:0]  sext_op,
  output logic [1:0]  wd_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign funct3      = inst[14:12];
  assign f7b         = inst[30];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    cls     = CL_ILL;
    alu_op  = ALU_ADD;
    sext_op = SEXT_I;
    wd_sel  = WD_ALU;
    case (opcode)
      OP_R: begin
        cls    = CL_R;
        alu_op = arith_op(funct3, f7b);
      end
      OP_I: begin
        // Only the shift-right immediate honours bit 30; ADDI never becomes SUB.
        cls    = CL_I;
        alu_op = arith_op(funct3, f7b && (funct3 == 3'b101));
      end
      OP_LOAD: begin
        cls    = CL_LOAD;
        wd_sel = WD_DRAM;
      end
      OP_STORE: begin
        cls     = CL_STORE;
        sext_op = SEXT_S;
      end
      OP_BRANCH: begin
        cls     = CL_BRANCH;
        sext_op = SEXT_B;
        alu_op  = branch_op(funct3);
      end
      OP_JAL: begin
        cls     = CL_JAL;
        sext_op = SEXT_J;
        wd_sel  = WD_PC4;
      end
      OP_JALR: begin
        cls    = CL_JALR;
        wd_sel = WD_PC4;
      end
      OP_LUI: begin
        cls     = CL_LUI;
        sext_op = SEXT_U;
        wd_sel  = WD_EXT;
      end
      OP_AUIPC: begin
        cls     = CL_AUIPC;
        sext_op = SEXT_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose : multi-cycle IF/ID/EX/MEM/WB sequencer for the shared miniRV execute stage, plus retired-instruction counter.
// Latency : 3 cycles branch/LUI, 4 ALU/AUIPC/JAL/JALR/store, 5 load, +1 per memory wait cycle.
// Backpressure: holds IF while imem_ready=0 and MEM while dmem_ready=0; ERR is held until reset.
// Ports: cpu_clk/cpu_rst_n; inst, alu_f, imem_ready, dmem_ready in; fetch/memory handshakes,
//        datapath selects (npc/alua/alub/alu_op/sext/wd), write enables, illegal, instret out.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic [31:0]          inst,
  input  logic                 alu_f,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           npc_sel,
  output logic                 alua_sel,
  output logic                 alub_sel,
  output logic [3:0]           alu_op,
  output logic [2:0]           sext_op,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic [1:0]           wd_sel,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  cls_e                 cls;
  logic [3:0]           dec_alu_op;
  logic [2:0]           dec_sext_op;
  logic [1:0]           dec_wd_sel;
  logic                 if_req;

  mc_decode u_decode (
    .inst    (inst),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .sext_op (dec_sext_op),
    .wd_sel  (dec_wd_sel)
  );

  always_comb begin
    state_d  = state_q;
    if_req   = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = NPC_PC4;
    alua_sel = ALUA_RD1;
    alub_sel = ALUB_RD2;
    alu_op   = ALU_ADD;
    sext_op  = SEXT_I;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wd_sel   = WD_ALU;

    if (state_q inside {ST_ID, ST_EX, ST_MEM, ST_WB}) begin
      sext_op = dec_sext_op;
    end
    // ALU controls stay put from EX through WB: MEM needs a stable address and
    // JALR's WB still consumes the rs1+imm result as the next PC.
    if (state_q inside {ST_EX, ST_MEM, ST_WB}) begin
      alua_sel = (cls == CL_AUIPC || cls == CL_JAL) ? ALUA_PC : ALUA_RD1;
      alub_sel = (cls == CL_R || cls == CL_BRANCH) ? ALUB_RD2 : ALUB_IMM;
      alu_op   = dec_alu_op;
    end

    case (state_q)
      ST_IF: begin
        if_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (cls == CL_ILL)      state_d = ST_ERR;
        else if (cls == CL_LUI) state_d = ST_WB;
        else                    state_d = ST_EX;
      end
      ST_EX: begin
        if (cls == CL_BRANCH) begin
          pc_we   = 1'b1;
          npc_sel = alu_f ? NPC_BR : NPC_PC4;
          state_d = ST_IF;
        end else if (cls == CL_LOAD || cls == CL_STORE) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CL_STORE);
        if (dmem_ready) begin
          if (cls == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        wd_sel  = dec_wd_sel;
        npc_sel = (cls == CL_JAL)  ? NPC_JAL  :
                  (cls == CL_JALR) ? NPC_JALR : NPC_PC4;
        state_d = ST_IF;
      end
      ST_ERR: ;
      default: state_d = ST_IF;
    endcase
  end

  // State resets to IF, which would otherwise raise the fetch request while
  // reset is still held; gating keeps every request low during reset.
  assign imem_req  = if_req & cpu_rst_n;
  assign illegal   = (state_q == ST_ERR);
  assign instret   = instret_q;
  assign instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, pc_we};

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= ST_IF;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Purpose : self-checking bench for mc_ctrl: directed literal scenarios plus randomized instruction stream vs. a cycle-sequence model.
// Latency : n/a.
// Backpressure: randomized imem/dmem wait cycles.
module tb_mc_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n;
  logic [31:0] inst;
  logic        alu_f, imem_ready, dmem_ready;
  logic        imem_req, ir_we, pc_we, alua_sel, alub_sel, dmem_req, dmem_we, rf_we, illegal;
  logic [1:0]  npc_sel, wd_sel;
  logic [3:0]  alu_op;
  logic [2:0]  sext_op;
  logic [31:0] instret;

  mc_ctrl #(.INSTRET_W(32)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .inst(inst), .alu_f(alu_f),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .alua_sel(alua_sel),
    .alub_sel(alub_sel), .alu_op(alu_op), .sext_op(sext_op), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .rf_we(rf_we), .wd_sel(wd_sel), .illegal(illegal),
    .instret(instret)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic        imem_req, ir_we, pc_we;
    logic [1:0]  npc_sel;
    logic        alua_sel, alub_sel;
    logic [3:0]  alu_op;
    logic [2:0]  sext_op;
    logic        dmem_req, dmem_we, rf_we;
    logic [1:0]  wd_sel;
    logic        illegal;
    logic [31:0] instret;
  } obs_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_inst = 0;
  obs_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.imem_req = imem_req; o.ir_we = ir_we; o.pc_we = pc_we; o.npc_sel = npc_sel;
    o.alua_sel = alua_sel; o.alub_sel = alub_sel; o.alu_op = alu_op; o.sext_op = sext_op;
    o.dmem_req = dmem_req; o.dmem_we = dmem_we; o.rf_we = rf_we; o.wd_sel = wd_sel;
    o.illegal = illegal; o.instret = instret;
    return o;
  endfunction

  // ---------------- reference model (instruction-level rules) ----------------
  function automatic int m_class(input logic [6:0] op);
    case (op)
      7'h33: return K_R;
      7'h13: return K_I;
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h63: return K_BR;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] m_alu(input int k, input logic [2:0] f3, input logic alt);
    logic [31:0] arith_tbl, br_tbl;
    arith_tbl = {4'd2, 4'd3, 4'd6, 4'd4, 4'd9, 4'd8, 4'd5, 4'd0};
    br_tbl    = {4'd13, 4'd9, 4'd12, 4'd8, 4'd10, 4'd10, 4'd11, 4'd10};
    if (k == K_BR) return br_tbl[f3*4 +: 4];
    if (k != K_R && k != K_I) return 4'd0;
    if (f3 == 3'd0 && alt && k == K_R) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd7;
    return arith_tbl[f3*4 +: 4];
  endfunction

  function automatic logic [2:0] m_sext(input int k);
    if (k == K_ST) return 3'd1;
    if (k == K_BR) return 3'd2;
    if (k == K_LUI || k == K_AUIPC) return 3'd3;
    if (k == K_JAL) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [1:0] m_wd(input int k);
    if (k == K_LD) return 2'd1;
    if (k == K_JAL || k == K_JALR) return 2'd2;
    if (k == K_LUI) return 2'd3;
    return 2'd0;
  endfunction

  // One model cycle: drive inputs just after the edge, queue what the outputs must be.
  task automatic step(input logic [31:0] i, input logic imr, input logic dmr,
                      input logic af, input obs_t e);
    @(posedge cpu_clk); #1;
    inst = i; imem_ready = imr; dmem_ready = dmr; alu_f = af;
    e.instret = m_inst;
    exp_q.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expand one instruction into the cycle-by-cycle output sequence it must produce.
  task automatic run_insn(input logic [31:0] ins, output bit was_ill);
    int k, iw, dw;
    logic f;
    obs_t e, ea;
    k  = m_class(ins[6:0]);
    iw = $urandom_range(0, 2);
    dw = $urandom_range(0, 3);
    f  = rb();
    was_ill = 0;
    for (int n = 0; n < iw; n++) begin
      e = '0; e.imem_req = 1;
      step($urandom, 0, rb(), rb(), e);
    end
    e = '0; e.imem_req = 1; e.ir_we = 1;
    step(ins, 1, rb(), rb(), e);
    e = '0; e.sext_op = m_sext(k);
    step(ins, rb(), rb(), rb(), e);
    if (k == K_ILL) begin
      e = '0; e.illegal = 1;
      repeat ($urandom_range(1, 5)) step(ins, rb(), rb(), rb(), e);
      was_ill = 1;
      return;
    end
    ea = '0;
    ea.sext_op  = m_sext(k);
    ea.alu_op   = m_alu(k, ins[14:12], ins[30]);
    ea.alua_sel = (k == K_AUIPC || k == K_JAL);
    ea.alub_sel = !(k == K_R || k == K_BR);
    if (k != K_LUI) begin
      e = ea;
      if (k == K_BR) begin
        e.pc_we = 1; e.npc_sel = f ? 2'd1 : 2'd0;
        step(ins, rb(), rb(), f, e);
        m_inst++;
        return;
      end
      step(ins, rb(), rb(), rb(), e);
    end
    if (k == K_LD || k == K_ST) begin
      e = ea; e.dmem_req = 1; e.dmem_we = (k == K_ST);
      for (int n = 0; n < dw; n++) step(ins, rb(), 0, rb(), e);
      if (k == K_ST) begin
        e.pc_we = 1;
        step(ins, rb(), 1, rb(), e);
        m_inst++;
        return;
      end
      step(ins, rb(), 1, rb(), e);
    end
    e = ea; e.rf_we = 1; e.pc_we = 1; e.wd_sel = m_wd(k);
    e.npc_sel = (k == K_JAL) ? 2'd2 : (k == K_JALR) ? 2'd3 : 2'd0;
    step(ins, rb(), rb(), rb(), e);
    m_inst++;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [62:0] ops;
    logic [6:0]  op;
    int          sel;
    ops = {7'h17, 7'h37, 7'h67, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13, 7'h33};
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 9) begin
      op = 7'($urandom);
      if (m_class(op) != K_ILL) op = 7'h7F;
    end else begin
      op = ops[sel*7 +: 7];
    end
    if (op == 7'h63 && r[14:13] == 2'b01) r[14] = 1'b1;
    r[6:0] = op;
    return r;
  endfunction

  task automatic do_reset();
    @(posedge cpu_clk); #1;
    imem_ready = 0; cpu_rst_n = 0;
    #2 cpu_rst_n = 1;
    m_inst = 0;
  endtask

  // Compare process: every queued model cycle is checked at the falling edge.
  always @(negedge cpu_clk) begin : cmp
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("model_cycle", 64'(sample()), 64'(e));
    end
  end

  // Directed helper: drive one cycle, settle, caller checks literals.
  task automatic drv(input logic [31:0] i, input logic imr, input logic dmr, input logic af);
    @(posedge cpu_clk); #1;
    inst = i; imem_ready = imr; dmem_ready = dmr; alu_f = af;
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] BEQ  = 32'h00000463;
  localparam logic [31:0] JALR = 32'h004100E7;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] BAD  = 32'h0000007F;

  initial begin : main
    obs_t e;
    bit   ill;
    inst = 0; imem_ready = 0; dmem_ready = 0; alu_f = 0; cpu_rst_n = 0;
    #7;
    chk("reset_outputs", 64'(sample()), 64'd0);
    #1 cpu_rst_n = 1;
    #1;
    e = '0; e.imem_req = 1;
    chk("post_reset", 64'(sample()), 64'(e));

    // addi x1,x0,5
    drv(ADDI, 1, 0, 0); chk("addi_if", 64'({imem_req, ir_we, pc_we, rf_we}), 64'(4'b1100));
    drv(ADDI, 0, 0, 0); chk("addi_id", 64'({sext_op, ir_we, pc_we, rf_we}), 64'd0);
    drv(ADDI, 0, 0, 0); chk("addi_ex", 64'({alua_sel, alub_sel, alu_op, pc_we, rf_we}), 64'(8'b0100_0000));
    drv(ADDI, 0, 0, 0); chk("addi_wb", 64'({rf_we, wd_sel, pc_we, npc_sel}), 64'(6'b100100));
    drv(ADDI, 0, 0, 0); chk("addi_instret", 64'({imem_req, instret}), 64'({1'b1, 32'd1}));

    // lw x2,0(x1) with three dmem wait cycles: IF ID EX MEMx4 WB = 8 cycles
    drv(LW, 1, 0, 0); chk("lw_if", 64'({ir_we, pc_we}), 64'(2'b10));
    drv(LW, 0, 0, 0); chk("lw_id", 64'({sext_op, pc_we}), 64'd0);
    drv(LW, 0, 0, 0); chk("lw_ex", 64'({alua_sel, alub_sel, alu_op, dmem_req, pc_we}), 64'(8'b0100_0000));
    for (int n = 0; n < 4; n++) begin
      drv(LW, 0, n == 3, 0);
      chk("lw_mem", 64'({dmem_req, dmem_we, alua_sel, alub_sel, alu_op, pc_we, rf_we}), 64'(10'b10_01_0000_00));
    end
    drv(LW, 0, 0, 0); chk("lw_wb", 64'({rf_we, wd_sel, pc_we, dmem_req}), 64'(5'b10110));

    // beq x0,x0,8 taken then not taken: retires in EX, no register write
    for (int t = 1; t >= 0; t--) begin
      drv(BEQ, 1, 0, 0);
      drv(BEQ, 0, 0, 0); chk("beq_id", 64'(sext_op), 64'd2);
      drv(BEQ, 0, 0, 1'(t));
      chk("beq_ex", 64'({alu_op, pc_we, npc_sel, rf_we}), 64'({4'd10, 1'b1, 2'(t), 1'b0}));
      drv(BEQ, 0, 0, 0); chk("beq_after", 64'({imem_req, rf_we, pc_we}), 64'(3'b100));
    end

    // jalr x1,4(x2)
    drv(JALR, 1, 0, 0);
    drv(JALR, 0, 0, 0);
    drv(JALR, 0, 0, 0); chk("jalr_ex", 64'({alu_op, alua_sel, alub_sel, pc_we}), 64'(7'b0000_010));
    drv(JALR, 0, 0, 0); chk("jalr_wb", 64'({rf_we, wd_sel, npc_sel, pc_we}), 64'(6'b1_10_11_1));
    drv(JALR, 0, 0, 0); chk("instret_after_5", 64'(instret), 64'd5);

    // Illegal opcode: ERR after ID, sticky, everything quiet until reset
    drv(BAD, 1, 0, 0);
    drv(BAD, 0, 0, 0); chk("bad_id_not_yet", 64'(illegal), 64'd0);
    e = '0; e.illegal = 1; e.instret = 32'd5;
    for (int n = 0; n < 100; n++) begin
      drv(BAD, rb(), rb(), rb());
      chk("err_hold", 64'(sample()), 64'(e));
    end
    @(posedge cpu_clk); #1 cpu_rst_n = 0; imem_ready = 0;
    #1 chk("err_reset", 64'({illegal, imem_req, instret}), 64'd0);
    #1 cpu_rst_n = 1;
    #1 chk("err_release", 64'({illegal, imem_req}), 64'(2'b01));

    // Reset during the MEM phase of a store
    drv(SW, 1, 0, 0);
    drv(SW, 0, 0, 0);
    drv(SW, 0, 0, 0);
    drv(SW, 0, 0, 0); chk("sw_mem", 64'({dmem_req, dmem_we, pc_we}), 64'(3'b110));
    #1 cpu_rst_n = 0;
    #1 chk("sw_async_drop", 64'({dmem_req, dmem_we, pc_we, rf_we, imem_req, ir_we, instret}), 64'd0);
    dmem_ready = 1;
    @(posedge cpu_clk); #1 cpu_rst_n = 1; dmem_ready = 0;
    #1 chk("sw_no_retire", 64'({imem_req, instret}), 64'({1'b1, 32'd0}));

    // Randomized instruction stream against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      run_insn(rand_inst(), ill);
      if (ill) do_reset();
    end
    @(negedge cpu_clk); #1;
    chk("model_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
